// File: rtl/axis_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_buffer
// Purpose  : Store-and-forward AXI-Stream frame buffer. Captures one frame
//            (data, strobe, last) into a register array, then replays it.
//            Frames longer than DEPTH words are truncated and flagged.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                    s01_axis_aclk,
  input  logic                    s01_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  input  logic                    m01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  output logic [CNT_W-1:0]        frame_len,
  output logic                    overflow
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST_SLOT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DISCARD = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  s_ready_q, s_ready_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  logic [CNT_W-1:0]      frame_len_q, frame_len_d;
  logic                  overflow_q, overflow_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [STRB_W-1:0]     m_strb_q, m_strb_d;

  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [STRB_W-1:0]     mem_strb_q [DEPTH];
  logic [DEPTH-1:0]      mem_last_q;

  logic                  wr_en;
  logic                  wr_last;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  s_fire;
  logic                  m_fire;
  logic [CNT_W-1:0]      rcnt_inc;
  logic [ADDR_W-1:0]     rd_addr;
  // First word of the frame to present at the commit edge. A single-word
  // frame commits from IDLE while entry[0] is still being written, so it is
  // taken straight from the input.
  logic [DATA_WIDTH-1:0] first_data;
  logic [STRB_W-1:0]     first_strb;
  logic                  first_last;

  // Next-state, counter, array-write and output-register logic
  always_comb begin
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    frame_len_d = frame_len_q;
    overflow_d  = 1'b0;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_data_d    = m_data_q;
    m_strb_d    = m_strb_q;
    wr_en       = 1'b0;
    wr_last     = s01_axis_tlast;
    wr_addr     = wcnt_q[ADDR_W-1:0];
    s_fire      = s_ready_q & s01_axis_tvalid;
    m_fire      = m_valid_q & m01_axis_tready;
    rcnt_inc    = rcnt_q + CNT_ONE;
    rd_addr     = rcnt_inc[ADDR_W-1:0];

    if (state_q == IDLE) begin
      first_data = s01_axis_tdata;
      first_strb = s01_axis_tstrb;
      first_last = s01_axis_tlast;
    end else begin
      first_data = mem_data_q[0];
      first_strb = mem_strb_q[0];
      first_last = mem_last_q[0];
    end

    case (state_q)
      IDLE, FILL: begin
        s_ready_d = 1'b1;
        if (s_fire) begin
          wr_en = 1'b1;
          if (s01_axis_tlast) begin
            frame_len_d = wcnt_q + CNT_ONE;
            wcnt_d      = '0;
            rcnt_d      = '0;
            s_ready_d   = 1'b0;
            state_d     = DRAIN;
            m_valid_d   = 1'b1;
            m_data_d    = first_data;
            m_strb_d    = first_strb;
            m_last_d    = first_last;
          end else if (wcnt_q == CNT_LAST_SLOT) begin
            // Array full: close the stored frame and swallow the remainder
            wr_last     = 1'b1;
            overflow_d  = 1'b1;
            frame_len_d = CNT_FULL;
            wcnt_d      = '0;
            state_d     = DISCARD;
          end else begin
            wcnt_d  = wcnt_q + CNT_ONE;
            state_d = FILL;
          end
        end
      end
      DISCARD: begin
        s_ready_d = 1'b1;
        if (s_fire && s01_axis_tlast) begin
          rcnt_d    = '0;
          s_ready_d = 1'b0;
          state_d   = DRAIN;
          m_valid_d = 1'b1;
          m_data_d  = first_data;
          m_strb_d  = first_strb;
          m_last_d  = first_last;
        end
      end
      DRAIN: begin
        s_ready_d = 1'b0;
        if (m_fire) begin
          if (rcnt_q == frame_len_q - CNT_ONE) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            rcnt_d    = '0;
            state_d   = IDLE;
          end else begin
            rcnt_d   = rcnt_inc;
            m_data_d = mem_data_q[rd_addr];
            m_strb_d = mem_strb_q[rd_addr];
            m_last_d = mem_last_q[rd_addr];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers with asynchronous reset
  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) begin
      state_q     <= IDLE;
      s_ready_q   <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      frame_len_q <= '0;
      overflow_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      m_strb_q    <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      frame_len_q <= frame_len_d;
      overflow_q  <= overflow_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      m_strb_q    <= m_strb_d;
    end
  end

  // Frame storage array; contents need no reset
  always_ff @(posedge s01_axis_aclk) begin
    if (wr_en) begin
      mem_data_q[wr_addr] <= s01_axis_tdata;
      mem_strb_q[wr_addr] <= s01_axis_tstrb;
      mem_last_q[wr_addr] <= wr_last;
    end
  end

  assign s01_axis_tready = s_ready_q;
  assign m01_axis_tdata  = m_data_q;
  assign m01_axis_tstrb  = m_strb_q;
  assign m01_axis_tvalid = m_valid_q;
  assign m01_axis_tlast  = m_last_q;
  assign frame_len       = frame_len_q;
  assign overflow        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_frame_buffer
// Purpose  : Scoreboard bench for axis_frame_buffer (DATA_WIDTH=32, DEPTH=16)
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      s_data = '0;
  logic [3:0]       s_strb = '0;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             m_ready = 1'b1;
  logic [31:0]      m_data;
  logic [3:0]       m_strb;
  logic             m_valid;
  logic             m_last;
  logic [CNT_W-1:0] frame_len;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int ovf_cnt = 0;
  logic [36:0] sb[$];

  axis_frame_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .s01_axis_aclk    (clk),
    .s01_axis_aresetn (rst_n),
    .s01_axis_tdata   (s_data),
    .s01_axis_tstrb   (s_strb),
    .s01_axis_tvalid  (s_valid),
    .s01_axis_tlast   (s_last),
    .s01_axis_tready  (s_ready),
    .m01_axis_tready  (m_ready),
    .m01_axis_tdata   (m_data),
    .m01_axis_tstrb   (m_strb),
    .m01_axis_tvalid  (m_valid),
    .m01_axis_tlast   (m_last),
    .frame_len        (frame_len),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Output monitor: any valid word must match the scoreboard head (also while
  // stalled); a word is popped when the coming edge completes the handshake.
  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (m_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got data=%h strb=%h last=%b, required no valid word", m_data, m_strb, m_last);
      end else begin
        if ({m_data, m_strb, m_last} !== sb[0]) begin
          errors++;
          $display("FAIL output_word: got data=%h strb=%h last=%b, required data=%h strb=%h last=%b",
                   m_data, m_strb, m_last, sb[0][36:5], sb[0][4:1], sb[0][0]);
        end
        if (m_ready === 1'b1) begin
          void'(sb.pop_front());
          xfer_cnt++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Drive one input word and hold it until accepted (caller sits at edge+1)
  task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    int t = 0;
    s_data = d; s_strb = s; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    while (s_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: got tready=%b, required 1 within 200 cycles", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input logic [3:0] strb);
    for (int i = 0; i < n; i++) begin
      if (i < DEPTH) sb.push_back({base + 32'(i), strb, (i == n - 1) || (i == DEPTH - 1)});
      send_word(base + 32'(i), strb, i == n - 1);
    end
  endtask

  // Wait until the output goes idle; returns the number of valid cycles
  task automatic wait_drain(output int cyc);
    int t = 0;
    cyc = 0;
    while (m_valid === 1'b1 && t < 300) begin
      cyc++;
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (m_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got tvalid=%b pending=%0d, required 0 and 0", m_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, m_valid, m_data, m_strb, m_last, frame_len, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_values: got tready=%b tvalid=%b data=%h strb=%h last=%b len=%0d ovf=%b, required all 0",
               s_ready, m_valid, m_data, m_strb, m_last, frame_len, overflow);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", s_ready);
    end
  endtask

  task automatic test_basic();
    int cyc;
    int x0 = xfer_cnt;
    int o0 = ovf_cnt;
    m_ready = 1'b1;
    send_frame(4, 32'hA0, 4'hF);
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: got tvalid=%b tready=%b, required 1 and 0", m_valid, s_ready);
    end
    wait_drain(cyc);
    checks++;
    if (cyc != 4 || xfer_cnt - x0 != 4) begin
      errors++;
      $display("FAIL basic_throughput: got cycles=%0d xfers=%0d, required 4 and 4", cyc, xfer_cnt - x0);
    end
    checks++;
    if (frame_len !== 5'd4 || ovf_cnt != o0) begin
      errors++;
      $display("FAIL basic_len: got len=%0d ovf_pulses=%0d, required 4 and 0", frame_len, ovf_cnt - o0);
    end
  endtask

  task automatic test_single();
    int cyc;
    int x0 = xfer_cnt;
    send_frame(1, 32'h55, 4'h3);
    wait_drain(cyc);
    checks++;
    if (frame_len !== 5'd1 || xfer_cnt - x0 != 1) begin
      errors++;
      $display("FAIL single_len: got len=%0d xfers=%0d, required 1 and 1", frame_len, xfer_cnt - x0);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    int x0 = xfer_cnt;
    int o0 = ovf_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i < DEPTH) sb.push_back({32'h100 + 32'(i), 4'hF, i == DEPTH - 1});
      send_word(32'h100 + 32'(i), 4'hF, i == 19);
      if (i == DEPTH - 1 || i == DEPTH) begin
        checks++;
        if (overflow !== (i == DEPTH - 1)) begin
          errors++;
          $display("FAIL overflow_pulse: after word %0d got %b, required %b", i + 1, overflow, i == DEPTH - 1);
        end
      end
    end
    wait_drain(cyc);
    checks++;
    if (frame_len !== 5'd16 || xfer_cnt - x0 != 16 || ovf_cnt - o0 != 1) begin
      errors++;
      $display("FAIL overflow_frame: got len=%0d xfers=%0d pulses=%0d, required 16 16 1",
               frame_len, xfer_cnt - x0, ovf_cnt - o0);
    end
  endtask

  task automatic test_stall();
    logic [5:0] pat = 6'b101001;  // bit i is tready in drain cycle i: 1,0,0,1,0,1
    int x0 = xfer_cnt;
    m_ready = 1'b0;
    send_frame(3, 32'hC0, 4'h5);
    for (int i = 0; i < 6; i++) begin
      m_ready = pat[i];
      checks++;
      if (s_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready: cycle %0d got tready=%b, required 0", i, s_ready);
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || xfer_cnt - x0 != 3) begin
      errors++;
      $display("FAIL stall_end: got tvalid=%b tready=%b xfers=%0d, required 0 0 3", m_valid, s_ready, xfer_cnt - x0);
    end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_reready: got %b, required 1", s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int x0 = xfer_cnt;
    m_ready = 1'b1;
    send_frame(2, 32'hD0, 4'hF);
    sb.push_back({32'hE0, 4'h0, 1'b0});
    send_word(32'hE0, 4'h0, 1'b0);
    checks++;
    if (xfer_cnt - x0 != 2) begin
      errors++;
      $display("FAIL b2b_order: second frame accepted after %0d xfers, required 2", xfer_cnt - x0);
    end
    sb.push_back({32'hE1, 4'h0, 1'b0});
    send_word(32'hE1, 4'h0, 1'b0);
    sb.push_back({32'hE2, 4'h0, 1'b1});
    send_word(32'hE2, 4'h0, 1'b1);
    wait_drain(cyc);
    checks++;
    if (frame_len !== 5'd3 || xfer_cnt - x0 != 5) begin
      errors++;
      $display("FAIL b2b_len: got len=%0d xfers=%0d, required 3 and 5", frame_len, xfer_cnt - x0);
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    int x0 = xfer_cnt;
    m_ready = 1'b1;
    send_frame(5, 32'hF0, 4'hF);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, m_valid, m_data, m_strb, m_last, frame_len, overflow} !== '0 || xfer_cnt - x0 != 2) begin
      errors++;
      $display("FAIL async_reset: got tvalid=%b data=%h len=%0d xfers=%0d, required all 0 and 2 xfers",
               m_valid, m_data, frame_len, xfer_cnt - x0);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    x0 = xfer_cnt;
    send_frame(2, 32'h70, 4'hC);
    wait_drain(cyc);
    checks++;
    if (frame_len !== 5'd2 || xfer_cnt - x0 != 2) begin
      errors++;
      $display("FAIL post_reset_frame: got len=%0d xfers=%0d, required 2 and 2", frame_len, xfer_cnt - x0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_mid_drain();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
